instr_fetch_ctrl: RTL

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Purpose:
//    Instruction fetch front end. It walks a program counter through a
//    combinational instruction ROM and buffers fetched words with their word
//    addresses in a two-entry queue for the decoder. Taken branches flush the
//    queue and restart fetch at the target. A program-end word stops fetch;
//    the queue drains and the block parks in HALT until the next start.
//
// Ports:
//    clock          - single clock, rising-edge active
//    reset          - asynchronous active-high reset
//    start          - begin fetching at RESET_PC (honoured in IDLE or HALT)
//    rom_addr       - word address presented to the ROM (always the pc)
//    rom_data       - ROM word for rom_addr, same cycle
//    redirect_valid - branch/jump taken this cycle (RUN or DRAIN only)
//    redirect_addr  - redirect target word address
//    instr          - instruction at the queue head (0 when empty)
//    instr_pc       - word address of instr (0 when empty)
//    instr_valid    - queue head is valid
//    instr_ready    - decoder accepts the head this cycle
//    halted         - high while in HALT
//    retired_count  - running count of instr handshakes, wraps at 2^32
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [31:0] HALT_WORD = 32'hD60003E0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic [15:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_addr,
   output logic [31:0] instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        halted,
   output logic [31:0] retired_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] retired_q, retired_d;
   // Queue entries are {instr, pc}; entry0 is always the head.
   logic [47:0] entry0_q, entry0_d;
   logic [47:0] entry1_q, entry1_d;

   logic redirect_take;
   logic restart;
   logic pop;
   logic fetch;
   logic halt_seen;
   logic push;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: pc, queue contents/occupancy and retire counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         count_q   <= 2'd0;
         retired_q <= 32'd0;
         entry0_q  <= 48'd0;
         entry1_q  <= 48'd0;
      end else begin
         pc_q      <= pc_d;
         count_q   <= count_d;
         retired_q <= retired_d;
         entry0_q  <= entry0_d;
         entry1_q  <= entry1_d;
      end
   end

   // Cycle control. A redirect wins over everything else and cancels both
   // the pop and the fetch. A fetch may proceed into a full queue only when
   // the head leaves in the same cycle, so the two never collide.
   always_comb begin
      redirect_take = redirect_valid && ((state_q == RUN) || (state_q == DRAIN));
      restart       = start && ((state_q == IDLE) || (state_q == HALT));
      pop           = (count_q != 2'd0) && instr_ready && !redirect_take;
      fetch         = (state_q == RUN) && !redirect_take && ((count_q != 2'd2) || pop);
      halt_seen     = fetch && (rom_data == HALT_WORD);
      push          = fetch && !halt_seen;
   end

   // Queue, pc and retire counter update. The pop shifts entry1 into the
   // head first; the push then lands in the first free slot after that.
   always_comb begin
      pc_d      = pc_q;
      count_d   = count_q;
      retired_d = retired_q;
      entry0_d  = entry0_q;
      entry1_d  = entry1_q;
      if (redirect_take) begin
         pc_d    = redirect_addr;
         count_d = 2'd0;
      end else if (restart) begin
         pc_d    = RESET_PC;
         count_d = 2'd0;
      end else begin
         if (pop) begin
            entry0_d  = entry1_q;
            count_d   = count_q - 2'd1;
            retired_d = retired_q + 32'd1;
         end
         if (push) begin
            if (count_d == 2'd0) begin
               entry0_d = {rom_data, pc_q};
            end else begin
               entry1_d = {rom_data, pc_q};
            end
            count_d = count_d + 2'd1;
            pc_d    = pc_q + 16'd1;
         end
      end
   end

   // Next-state logic. DRAIN leaves for HALT as soon as the queue will be
   // empty after this cycle's pop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (redirect_take) begin
               state_d = RUN;
            end else if (halt_seen) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (redirect_take) begin
               state_d = RUN;
            end else if (count_d == 2'd0) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (start) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs. The head fields are forced to zero whenever the queue is empty.
   always_comb begin
      rom_addr      = pc_q;
      instr_valid   = (count_q != 2'd0);
      instr         = instr_valid ? entry0_q[47:16] : 32'd0;
      instr_pc      = instr_valid ? entry0_q[15:0] : 16'd0;
      halted        = (state_q == HALT);
      retired_count = retired_q;
   end

endmodule
